timer_dev: RTL and testbench
============================

# timer_dev

Memory-mapped countdown timer that sits downstream of the pipelined CPU's M-stage data port (behind the address bridge) and drives one bit of the CPU's `HWInt[5:0]`. Software programs it with store words and reads it with load words. A four-state FSM loads a preset, counts down, and raises an interrupt request, in either one-shot or auto-reload mode.

## Interface
- Parameters: none. All registers are fixed at 32 bits.
- `clk` — input, 1 — system clock; all state updates on the rising edge.
- `reset` — input, 1 — asynchronous, active-low reset.
- `addr` — input, 2 — word offset, taken from data address bits [3:2]:
  - 0 = CTRL
  - 1 = PRESET
  - 2 = COUNT
  - 3 = reserved
- `we` — input, 1 — write strobe from the bridge (device selected and store in M).
- `byteen` — input, 4 — byte-lane enables for the write.
- `wdata` — input, 32 — store data, already lane-aligned.
- `rdata` — output, 32 — combinational read of the register selected by `addr`.
- `irq` — output, 1 — interrupt request to `HWInt`.

## Operation
- **Registers**
  - CTRL[0] = EN, CTRL[2:1] = MODE, CTRL[3] = IM (interrupt mask). CTRL[31:4] are not stored and read as 0.
  - PRESET is 32 bits, read/write.
  - COUNT is 32 bits, read-only; writes to it are ignored.
  - Offset 3 reads 0; writes to offset 3 are ignored.
- **Write rule**
  - A write occurs iff `we` and `|byteen`.
  - Each byte lane i with `byteen[i]=1` replaces byte i of the target register; other lanes are kept.
- **Write priority**
  - In a write cycle, the FSM, COUNT and the IRQ flag all hold. The CPU write is the only update that cycle.
  - Exception: any CTRL write clears the IRQ flag.
- **FSM states**
  - IDLE: if EN=1, go to LOAD; otherwise stay. COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN=0, go to IDLE; COUNT holds.
    - Else if COUNT > 1, COUNT <= COUNT-1.
    - Else (COUNT is 0 or 1), COUNT <= 0, IRQ flag <= 1, go to INT.
  - INT:
    - MODE=1: IRQ flag <= 0; go to IDLE. EN stays 1, so the timer reloads.
    - Any other MODE (0, 2, 3): CTRL[0] <= 0; go to IDLE. The IRQ flag stays set until the next CTRL write.
- **Output rules**
  - `irq` = IRQ flag & CTRL[3], registered-flag based, no combinational path from `wdata`.
  - `rdata` = CTRL (zero-extended) / PRESET / COUNT / 0, selected by `addr`. It is combinational and shows pre-edge values in a write cycle.

## Timing
- **Reset** (asynchronous, `reset`=0):
  - CTRL=0, PRESET=0, COUNT=0, state=IDLE, IRQ flag=0.
  - So `irq`=0, and `rdata` reads 0 for every offset.
  - Reset mid-count aborts immediately; no `irq` is produced.
- **Latency from the CTRL write edge** (edge w, with PRESET=P≥1):
  - LOAD at edge w+1.
  - COUNT=P after edge w+2.
  - COUNT reaches 0, and the IRQ flag sets, at edge w+P+2.
  - `irq` is visible during cycle w+P+2..(w+P+3) when IM=1.
- **Mode 1**
  - The flag clears at edge w+P+3, so `irq` is high for exactly 1 cycle.
  - Reload (LOAD) happens at w+P+4, so the period is P+3 cycles.
- **Mode 0**
  - EN clears at edge w+P+3.
  - `irq` stays high until the edge after a CTRL write.
- **Boundary cases**
  - PRESET=0 behaves like PRESET=1: INT one edge after LOAD.
  - No wrap-around: COUNT never decrements below 0.
  - If a write coincides with an FSM step, the write wins and the FSM step is deferred one cycle.
  - Writing PRESET during CNT does not affect COUNT until the next LOAD.

## Test plan
- **Mode 0 one-shot**
  - Stimulus: reset; PRESET=3; CTRL=0x9.
  - Required: COUNT reads 3, 2, 1, 0 on successive cycles; `irq` rises 5 edges after the CTRL write and stays high; CTRL reads 0x8 after INT; writing CTRL=0 drops `irq` next cycle.
- **Mode 1 periodic**
  - Stimulus: PRESET=2; CTRL=0xB.
  - Required: `irq` single-cycle pulses every 5 cycles; CTRL stays 0xB; COUNT cycles 2, 1, 0.
- **Masking and disable**
  - Stimulus: CTRL=0x1 (IM=0), PRESET=4; later CTRL=0x0 written mid-count at COUNT=2.
  - Required: `irq` never asserts; COUNT freezes at 2; state returns to IDLE.
- **Byte-enable writes and readback**
  - Stimulus: write PRESET=0x12345678 with byteen=4'b0011, then 0xAABBCCDD with 4'b1100.
  - Required: PRESET reads 0xAABB5678.
  - Stimulus: write COUNT and offset 3; write CTRL=0xFFFFFFFF.
  - Required: COUNT and offset 3 are unchanged and read as before; CTRL reads 0xF.
- **Write/FSM collision**
  - Stimulus: during CNT with COUNT=5, write PRESET every cycle for 3 cycles.
  - Required: COUNT holds at 5 for those 3 cycles, then resumes decrementing from 5.
- **Asynchronous reset mid-count**
  - Stimulus: assert `reset`=0 between edges while COUNT=2, mode 1.
  - Required: all registers read 0 and `irq`=0 immediately, without waiting for a clock edge; after release, the timer stays idle until CTRL is rewritten.

Source files
------------

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, four-state FSM, masked interrupt.
// Combinational readback; a bus write freezes the FSM for that cycle.
module timer_dev (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);
   typedef enum logic [1:0] {IDLE, LOAD, CNT, INTR} state_t;

   state_t      state;
   logic [3:0]  ctrl;
   logic [31:0] preset;
   logic [31:0] count;
   logic        irq_flag;
   logic        wr;
   logic [31:0] preset_merged;

   assign wr = we & (|byteen);

   always_comb begin
      preset_merged = preset;
      for (int i = 0; i < 4; i++) begin
         if (byteen[i]) preset_merged[8*i +: 8] = wdata[8*i +: 8];
      end
   end

   // A CPU write takes the whole cycle: FSM, COUNT and flag hold unless the write hits CTRL.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         ctrl     <= 4'd0;
         preset   <= 32'd0;
         count    <= 32'd0;
         irq_flag <= 1'b0;
      end else if (wr) begin
         case (addr)
            2'd0: begin
               if (byteen[0]) ctrl <= wdata[3:0];
               irq_flag <= 1'b0;
            end
            2'd1:    preset <= preset_merged;
            default: ;
         endcase
      end else begin
         case (state)
            IDLE: if (ctrl[0]) state <= LOAD;
            LOAD: begin
               count <= preset;
               state <= CNT;
            end
            CNT: begin
               if (!ctrl[0]) begin
                  state <= IDLE;
               end else if (count > 32'd1) begin
                  count <= count - 32'd1;
               end else begin
                  count    <= 32'd0;
                  irq_flag <= 1'b1;
                  state    <= INTR;
               end
            end
            INTR: begin
               // Mode 1 auto-reloads by leaving EN set; other modes are one-shot.
               if (ctrl[2:1] == 2'd1) irq_flag <= 1'b0;
               else                   ctrl[0]  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      case (addr)
         2'd0:    rdata = {28'd0, ctrl};
         2'd1:    rdata = preset;
         2'd2:    rdata = count;
         default: rdata = 32'd0;
      endcase
   end

   assign irq = irq_flag & ctrl[3];

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: expectations are queued as stimulus is driven, popped as outputs are sampled.
module tb_timer_dev;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic        we = 1'b0;
   logic [3:0]  byteen = 4'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        irq;

   int total = 0;
   int bad = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];

   timer_dev dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .we     (we),
      .byteen (byteen),
      .wdata  (wdata),
      .rdata  (rdata),
      .irq    (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL sb_underflow: got 0x%08h want nothing queued", obs);
      end else begin
         e = sb.pop_front();
         chk(e.tag, obs, e.val);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
      addr   = a;
      wdata  = d;
      byteen = be;
      we     = 1'b1;
      step();
      we     = 1'b0;
      byteen = 4'd0;
   endtask

   task automatic sample_rd(input logic [1:0] a);
      addr = a;
      #1;
      pop_chk(rdata);
   endtask

   task automatic sample_irq();
      pop_chk({31'd0, irq});
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time budget");
      $fatal(1, "timeout");
   end

   initial begin
      int ph;
      logic [31:0] c;

      // reset state
      #12;
      for (int a = 0; a < 4; a++) begin
         push("rst_rd", 32'd0);
         sample_rd(a[1:0]);
      end
      push("rst_irq", 32'd0);
      sample_irq();
      reset = 1'b1;
      step();

      // mode 0 one-shot, PRESET=3
      wr(2'd1, 32'd3, 4'hF);
      wr(2'd0, 32'h9, 4'hF);
      for (int k = 1; k <= 8; k++) begin
         c = (k == 2) ? 32'd3 : (k == 3) ? 32'd2 : (k == 4) ? 32'd1 : 32'd0;
         push("m0_cnt", c);
         push("m0_irq", (k >= 5) ? 32'd1 : 32'd0);
      end
      for (int k = 1; k <= 8; k++) begin
         step();
         sample_rd(2'd2);
         sample_irq();
      end
      push("m0_ctrl_after_int", 32'h8);
      sample_rd(2'd0);
      wr(2'd0, 32'h0, 4'hF);
      push("m0_irq_cleared", 32'd0);
      sample_irq();

      // mode 1 periodic, PRESET=2
      wr(2'd1, 32'd2, 4'hF);
      wr(2'd0, 32'hB, 4'hF);
      for (int k = 1; k <= 15; k++) begin
         ph = (k - 1) % 5;
         push("m1_cnt", (ph == 1) ? 32'd2 : (ph == 2) ? 32'd1 : 32'd0);
         push("m1_irq", (ph == 3) ? 32'd1 : 32'd0);
         push("m1_ctrl", 32'hB);
      end
      for (int k = 1; k <= 15; k++) begin
         step();
         sample_rd(2'd2);
         sample_irq();
         sample_rd(2'd0);
      end
      wr(2'd0, 32'h0, 4'hF);
      step();
      step();

      // masked, then disabled mid-count at COUNT=2
      wr(2'd1, 32'd4, 4'hF);
      wr(2'd0, 32'h1, 4'hF);
      for (int k = 1; k <= 9; k++) begin
         c = (k == 2) ? 32'd4 : (k == 3) ? 32'd3 : (k >= 4) ? 32'd2 : 32'd0;
         push("mask_cnt", c);
         push("mask_irq", 32'd0);
      end
      for (int k = 1; k <= 9; k++) begin
         if (k == 5) wr(2'd0, 32'h0, 4'hF);
         else        step();
         sample_rd(2'd2);
         sample_irq();
      end

      // byte lanes and read-only / reserved offsets
      wr(2'd1, 32'h12345678, 4'b0011);
      push("be_lo", 32'h00005678);
      sample_rd(2'd1);
      wr(2'd1, 32'hAABBCCDD, 4'b1100);
      push("be_hi", 32'hAABB5678);
      sample_rd(2'd1);
      wr(2'd1, 32'hFFFFFFFF, 4'b0000);
      push("be_none", 32'hAABB5678);
      sample_rd(2'd1);
      wr(2'd2, 32'hDEADBEEF, 4'hF);
      push("cnt_ro", 32'd2);
      sample_rd(2'd2);
      wr(2'd3, 32'hDEADBEEF, 4'hF);
      push("off3", 32'd0);
      sample_rd(2'd3);
      wr(2'd0, 32'hFFFFFFFF, 4'hF);
      push("ctrl_ff", 32'hF);
      sample_rd(2'd0);
      push("ctrl_ff_irq", 32'd0);
      sample_irq();
      wr(2'd0, 32'h0, 4'hF);
      push("cnt_after_be", 32'd2);
      sample_rd(2'd2);
      step();
      step();

      // write/FSM collision at COUNT=5
      wr(2'd1, 32'd8, 4'hF);
      wr(2'd0, 32'h1, 4'hF);
      for (int k = 1; k <= 5; k++) begin
         push("col_pre", (k == 1) ? 32'd2 : 32'(10 - k));
      end
      for (int k = 1; k <= 5; k++) begin
         step();
         sample_rd(2'd2);
      end
      for (int i = 0; i < 3; i++) begin
         push("col_hold", 32'd5);
      end
      for (int i = 0; i < 3; i++) begin
         wr(2'd1, 32'd100 + 32'(i), 4'hF);
         sample_rd(2'd2);
      end
      push("col_resume", 32'd4);
      push("col_resume", 32'd3);
      for (int i = 0; i < 2; i++) begin
         step();
         sample_rd(2'd2);
      end
      wr(2'd0, 32'h0, 4'hF);
      step();
      step();

      // asynchronous reset mid-count, mode 1
      wr(2'd1, 32'd4, 4'hF);
      wr(2'd0, 32'hB, 4'hF);
      push("ar_cnt", 32'd3);
      push("ar_cnt", 32'd4);
      push("ar_cnt", 32'd3);
      push("ar_cnt", 32'd2);
      for (int k = 1; k <= 4; k++) begin
         step();
         sample_rd(2'd2);
      end
      #1;
      reset = 1'b0;
      for (int a = 0; a < 4; a++) begin
         push("ar_rd", 32'd0);
         sample_rd(a[1:0]);
      end
      push("ar_irq", 32'd0);
      sample_irq();
      #1;
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         push("ar_idle_cnt", 32'd0);
         push("ar_idle_irq", 32'd0);
      end
      for (int k = 0; k < 6; k++) begin
         step();
         sample_rd(2'd2);
         sample_irq();
      end

      // PRESET=0 after reset behaves like PRESET=1
      wr(2'd0, 32'hB, 4'hF);
      push("p0_irq", 32'd0);
      push("p0_irq", 32'd0);
      push("p0_irq", 32'd1);
      push("p0_irq", 32'd0);
      for (int k = 1; k <= 4; k++) begin
         step();
         sample_irq();
      end

      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
